hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum consecutive data-memory wait cycles before halt.
REQ-002 SHALL have port i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_id_rs, i_id_rt  in  5 each  source registers of the instruction in IF/ID.
REQ-005 SHALL have ports i_ex_rs, i_ex_rt  in  5 each  source registers held in ID/EX.
REQ-006 SHALL have ports i_ex_mem_read  in  1, i_ex_write_reg  in  5  load flag and destination in ID/EX.
REQ-007 SHALL have ports i_mem_reg_write  in  1, i_mem_write_reg  in  5  EX/MEM write-back control and destination.
REQ-008 SHALL have ports i_wb_reg_write  in  1, i_wb_write_reg  in  5  MEM/WB write-back control and destination.
REQ-009 SHALL have port i_mem_branch_taken  in  1  branch control AND zero flag from EX/MEM.
REQ-010 SHALL have ports i_dmem_req, i_dmem_ready  in  1 each  data-memory access active in MEM; memory completes this cycle.
REQ-011 SHALL have ports o_pc_write, o_if_id_write  out  1 each  enables for PC and IF/ID.
REQ-012 SHALL have ports o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush  out  1 each  load all-zero bubble.
REQ-013 SHALL have port o_hold  out  1  freezes ID/EX and EX/MEM.
REQ-014 SHALL have ports o_fwd_a, o_fwd_b  out  2 each  ALU operand select: 00 register file, 01 MEM/WB, 10 EX/MEM.
REQ-015 SHALL have ports o_stall_cnt, o_flush_cnt  out  16 each  performance counters; o_error  out  1  halt flag; o_state  out  2.

Function
REQ-016 SHALL implement states RUN=00, MEM_WAIT=01, ERR=10; registered, all other outputs combinational from state and inputs.
REQ-017 Forwarding: o_fwd_a SHALL be 10 if i_mem_reg_write, i_mem_write_reg!=0, i_mem_write_reg==i_ex_rs; else 01 if same test on WB; else 00. o_fwd_b identical against i_ex_rt. Computed in every state.
REQ-018 Defaults: o_pc_write=1, o_if_id_write=1, all flushes and o_hold=0.
REQ-019 RUN, priority 1: i_dmem_req & !i_dmem_ready SHALL drive o_pc_write=0, o_if_id_write=0, o_hold=1, o_mem_wb_flush=1 same cycle; next state MEM_WAIT; wait counter loads 1.
REQ-020 RUN, priority 2: i_mem_branch_taken SHALL drive o_if_id_flush, o_id_ex_flush, o_ex_mem_flush=1, o_pc_write=1; o_flush_cnt +1.
REQ-021 RUN, priority 3 (load-use): i_ex_mem_read, i_ex_write_reg!=0, equal to i_id_rs or i_id_rt SHALL drive o_pc_write=0, o_if_id_write=0, o_id_ex_flush=1; o_stall_cnt +1.
REQ-022 MEM_WAIT: REQ-019 outputs held; o_stall_cnt +1 per cycle; i_dmem_ready=1 SHALL release outputs that cycle (defaults) and return to RUN.
REQ-023 MEM_WAIT: wait counter increments each non-ready cycle; reaching WAIT_MAX with i_dmem_ready=0 SHALL enter ERR next edge.
REQ-024 ERR: o_pc_write=0, o_if_id_write=0, o_hold=1, o_mem_wb_flush=1, o_error=1; only exit is reset.
REQ-025 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-026 Branch-taken and load-use together SHALL resolve as branch only; load-use squashed by flush.

Reset
REQ-027 Asserting i_rst_n=0 SHALL immediately force state RUN, wait counter 0, o_stall_cnt=0, o_flush_cnt=0, o_error=0, including mid-MEM_WAIT or ERR.
REQ-028 With idle inputs during/after reset: o_pc_write=1, o_if_id_write=1, flushes=0, o_hold=0, o_fwd_a=o_fwd_b=00, o_state=00.

Structure
REQ-029 Shared package hazard_pkg SHALL hold state encodings, forwarding select codes, default WAIT_MAX.
REQ-030 Forwarding logic SHALL be one combinational sub-module fwd_unit, instantiated once per operand.

Verification
REQ-031 Load-use: ex_mem_read=1, ex_write_reg=5, id_rs=5 -> one cycle pc_write=0, id_ex_flush=1; stall_cnt=1.
REQ-032 Forwarding: mem_reg_write=1, mem_write_reg=3, wb write_reg=3, ex_rs=3 -> fwd_a=10; mem_write_reg=0 -> fwd_a=01.
REQ-033 Branch + load-use same cycle -> three flushes, pc_write=1, flush_cnt=1, stall_cnt=0.
REQ-034 dmem_req=1, ready low 3 cycles then high -> hold=1 for 3 cycles, state 01 then 00, stall_cnt=3.
REQ-035 ready low 15 cycles -> state 10, error=1 persists; rst_n pulse mid-ERR -> state 00, counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// forwarding select codes, default wait budget and a saturating increment.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned WAIT_MAX_DEF = 15;
  localparam int unsigned CNT_W        = 16;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one ALU source: the youngest in-flight
// writer (EX/MEM) wins over MEM/WB; register 0 is never forwarded.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_mem_write_reg,
  input  logic       i_wb_reg_write,
  input  logic [4:0] i_wb_write_reg,
  output fwd_sel_e   o_sel
);

  // Priority select: EX/MEM, then MEM/WB, else register file.
  always_comb begin
    o_sel = FWD_RF;
    if (i_mem_reg_write && (i_mem_write_reg != '0) && (i_mem_write_reg == i_src)) begin
      o_sel = FWD_MEM;
    end else if (i_wb_reg_write && (i_wb_write_reg != '0) && (i_wb_write_reg == i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait freeze with timeout halt,
// branch flush, load-use stall, operand forwarding and saturating
// stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
)(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic [4:0]  i_ex_rs,
  input  logic [4:0]  i_ex_rt,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_write_reg,
  input  logic        i_mem_reg_write,
  input  logic [4:0]  i_mem_write_reg,
  input  logic        i_wb_reg_write,
  input  logic [4:0]  i_wb_write_reg,
  input  logic        i_mem_branch_taken,
  input  logic        i_dmem_req,
  input  logic        i_dmem_ready,
  output logic        o_pc_write,
  output logic        o_if_id_write,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_ex_mem_flush,
  output logic        o_mem_wb_flush,
  output logic        o_hold,
  output logic [1:0]  o_fwd_a,
  output logic [1:0]  o_fwd_b,
  output logic [15:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt,
  output logic        o_error,
  output logic [1:0]  o_state
);

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic             freeze, br_flush, lu_stall;
  logic             load_use;
  fwd_sel_e         fwd_a_sel, fwd_b_sel;

  fwd_unit u_fwd_a (
    .i_src           (i_ex_rs),
    .i_mem_reg_write (i_mem_reg_write),
    .i_mem_write_reg (i_mem_write_reg),
    .i_wb_reg_write  (i_wb_reg_write),
    .i_wb_write_reg  (i_wb_write_reg),
    .o_sel           (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .i_src           (i_ex_rt),
    .i_mem_reg_write (i_mem_reg_write),
    .i_mem_write_reg (i_mem_write_reg),
    .i_wb_reg_write  (i_wb_reg_write),
    .i_wb_write_reg  (i_wb_write_reg),
    .o_sel           (fwd_b_sel)
  );

  assign o_fwd_a = fwd_a_sel;
  assign o_fwd_b = fwd_b_sel;

  assign load_use = i_ex_mem_read && (i_ex_write_reg != '0) &&
                    ((i_ex_write_reg == i_id_rs) || (i_ex_write_reg == i_id_rt));

  // Next state, wait budget and hazard actions; freeze beats branch beats load-use.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    freeze    = 1'b0;
    br_flush  = 1'b0;
    lu_stall  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (i_dmem_req && !i_dmem_ready) begin
          freeze  = 1'b1;
          wait_d  = 16'd1;
          state_d = (WAIT_MAX <= 1) ? ST_ERR : ST_MEM_WAIT;
        end else if (i_mem_branch_taken) begin
          br_flush  = 1'b1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          lu_stall  = 1'b1;
          stall_inc = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        stall_inc = 1'b1;
        if (i_dmem_ready) begin
          wait_d  = '0;
          state_d = ST_RUN;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + 16'd1;
          if (32'(wait_q) + 32'd1 >= WAIT_MAX) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Pipeline control outputs derived from the selected action.
  always_comb begin
    o_pc_write     = !(freeze || lu_stall);
    o_if_id_write  = !(freeze || lu_stall);
    o_hold         = freeze;
    o_mem_wb_flush = freeze;
    o_if_id_flush  = br_flush;
    o_ex_mem_flush = br_flush;
    o_id_ex_flush  = br_flush || lu_stall;
  end

  // State, wait counter and performance counters; async active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= sat_inc(stall_q, stall_inc);
      flush_q <= sat_inc(flush_q, flush_inc);
    end
  end

  assign o_stall_cnt = stall_q;
  assign o_flush_cnt = flush_q;
  assign o_error     = (state_q == ST_ERR);
  assign o_state     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run checked against a run-length based behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned WMAX = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
  logic        ex_mem_read, mem_reg_write, wb_reg_write, branch, req, ready;
  logic        o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush;
  logic        o_ex_mem_flush, o_mem_wb_flush, o_hold, o_error;
  logic [1:0]  o_fwd_a, o_fwd_b, o_state;
  logic [15:0] o_stall_cnt, o_flush_cnt;
  logic [13:0] ctl;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.WAIT_MAX(WMAX)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_id_rs            (id_rs),
    .i_id_rt            (id_rt),
    .i_ex_rs            (ex_rs),
    .i_ex_rt            (ex_rt),
    .i_ex_mem_read      (ex_mem_read),
    .i_ex_write_reg     (ex_write_reg),
    .i_mem_reg_write    (mem_reg_write),
    .i_mem_write_reg    (mem_write_reg),
    .i_wb_reg_write     (wb_reg_write),
    .i_wb_write_reg     (wb_write_reg),
    .i_mem_branch_taken (branch),
    .i_dmem_req         (req),
    .i_dmem_ready       (ready),
    .o_pc_write         (o_pc_write),
    .o_if_id_write      (o_if_id_write),
    .o_if_id_flush      (o_if_id_flush),
    .o_id_ex_flush      (o_id_ex_flush),
    .o_ex_mem_flush     (o_ex_mem_flush),
    .o_mem_wb_flush     (o_mem_wb_flush),
    .o_hold             (o_hold),
    .o_fwd_a            (o_fwd_a),
    .o_fwd_b            (o_fwd_b),
    .o_stall_cnt        (o_stall_cnt),
    .o_flush_cnt        (o_flush_cnt),
    .o_error            (o_error),
    .o_state            (o_state)
  );

  always #5 clk = ~clk;

  assign ctl = {o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush, o_ex_mem_flush,
                o_mem_wb_flush, o_hold, o_error, o_state, o_fwd_a, o_fwd_b};

  // Builds an expected control word in the same bit order as ctl.
  function automatic logic [13:0] mk(input logic pc, ifid, fif, fid, fex, fwb, hold, err,
                                     input logic [1:0] st, fa, fb);
    return {pc, ifid, fif, fid, fex, fwb, hold, err, st, fa, fb};
  endfunction

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
    ex_mem_read = 1'b0; ex_write_reg = '0;
    mem_reg_write = 1'b0; mem_write_reg = '0;
    wb_reg_write = 1'b0; wb_write_reg = '0;
    branch = 1'b0; req = 1'b0; ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ctl !== mk(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00)) begin
      n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, mk(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    end
    n_vec++;
    if (o_stall_cnt !== 16'd0 || o_flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0/0", o_stall_cnt, o_flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    ex_mem_read = 1'b1; ex_write_reg = 5'd5; id_rs = 5'd5;
    #1;
    n_vec++;
    if (ctl !== mk(0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00)) begin
      n_err++; $display("FAIL load_use_ctl: got %b want %b", ctl, mk(0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00));
    end
    @(negedge clk);
    idle();
    #1;
    n_vec++;
    if (ctl !== mk(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00) || o_stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL load_use_after: got ctl=%b stall=%0d want ctl=%b stall=1",
                        ctl, o_stall_cnt, mk(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    @(negedge clk);
    mem_reg_write = 1'b1; mem_write_reg = 5'd3; wb_reg_write = 1'b1; wb_write_reg = 5'd3;
    ex_rs = 5'd3; ex_rt = 5'd3;
    #1;
    n_vec++;
    if (o_fwd_a !== 2'b10 || o_fwd_b !== 2'b10) begin
      n_err++; $display("FAIL fwd_mem: got a=%b b=%b want 10/10", o_fwd_a, o_fwd_b);
    end
    mem_write_reg = 5'd0;
    #1;
    n_vec++;
    if (o_fwd_a !== 2'b01 || o_fwd_b !== 2'b01) begin
      n_err++; $display("FAIL fwd_wb: got a=%b b=%b want 01/01", o_fwd_a, o_fwd_b);
    end
    wb_write_reg = 5'd0;
    #1;
    n_vec++;
    if (o_fwd_a !== 2'b00 || o_fwd_b !== 2'b00) begin
      n_err++; $display("FAIL fwd_r0: got a=%b b=%b want 00/00", o_fwd_a, o_fwd_b);
    end
    mem_write_reg = 5'd3; wb_write_reg = 5'd7; ex_rt = 5'd7; wb_reg_write = 1'b1;
    #1;
    n_vec++;
    if (o_fwd_a !== 2'b10 || o_fwd_b !== 2'b01) begin
      n_err++; $display("FAIL fwd_split: got a=%b b=%b want 10/01", o_fwd_a, o_fwd_b);
    end
    mem_reg_write = 1'b0;
    #1;
    n_vec++;
    if (o_fwd_a !== 2'b00 || o_fwd_b !== 2'b01) begin
      n_err++; $display("FAIL fwd_nowrite: got a=%b b=%b want 00/01", o_fwd_a, o_fwd_b);
    end
  endtask

  task automatic test_branch_load_use();
    do_reset();
    @(negedge clk);
    branch = 1'b1; ex_mem_read = 1'b1; ex_write_reg = 5'd4; id_rt = 5'd4;
    #1;
    n_vec++;
    if (ctl !== mk(1,1,1,1,1,0,0,0,2'b00,2'b00,2'b00)) begin
      n_err++; $display("FAIL branch_ctl: got %b want %b", ctl, mk(1,1,1,1,1,0,0,0,2'b00,2'b00,2'b00));
    end
    @(negedge clk);
    idle();
    #1;
    n_vec++;
    if (o_flush_cnt !== 16'd1 || o_stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL branch_cnt: got flush=%0d stall=%0d want 1/0", o_flush_cnt, o_stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    logic [13:0] frz0, frz1;
    frz0 = mk(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
    frz1 = mk(0,0,0,0,0,1,1,0,2'b01,2'b00,2'b00);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = 1'b1; ready = 1'b0;
      #1;
      n_vec++;
      if (ctl !== ((k == 0) ? frz0 : frz1) || o_stall_cnt !== 16'((k == 0) ? 0 : k - 1)) begin
        n_err++; $display("FAIL mem_wait_c%0d: got ctl=%b stall=%0d want ctl=%b stall=%0d",
                          k, ctl, o_stall_cnt, (k == 0) ? frz0 : frz1, (k == 0) ? 0 : k - 1);
      end
    end
    @(negedge clk);
    ready = 1'b1;
    #1;
    n_vec++;
    if (ctl !== mk(1,1,0,0,0,0,0,0,2'b01,2'b00,2'b00)) begin
      n_err++; $display("FAIL mem_wait_release: got %b want %b", ctl, mk(1,1,0,0,0,0,0,0,2'b01,2'b00,2'b00));
    end
    @(negedge clk);
    idle();
    #1;
    n_vec++;
    if (o_state !== 2'b00 || o_stall_cnt !== 16'd3) begin
      n_err++; $display("FAIL mem_wait_done: got state=%b stall=%0d want 00/3", o_state, o_stall_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [13:0] errv;
    errv = mk(0,0,0,0,0,1,1,1,2'b10,2'b00,2'b00);
    // One cycle short of the budget still recovers.
    do_reset();
    for (int k = 1; k <= int'(WMAX); k++) begin
      @(negedge clk);
      req = 1'b1; ready = (k == int'(WMAX));
    end
    #1;
    n_vec++;
    if (o_state !== 2'b01 || o_error !== 1'b0) begin
      n_err++; $display("FAIL wait_below_max: got state=%b err=%b want 01/0", o_state, o_error);
    end
    @(negedge clk);
    idle();
    #1;
    n_vec++;
    if (o_state !== 2'b00 || o_error !== 1'b0 || o_stall_cnt !== 16'(WMAX - 1)) begin
      n_err++; $display("FAIL wait_below_max_done: got state=%b err=%b stall=%0d want 00/0/%0d",
                        o_state, o_error, o_stall_cnt, WMAX - 1);
    end
    // Full budget of not-ready cycles halts.
    do_reset();
    for (int k = 1; k <= int'(WMAX); k++) begin
      @(negedge clk);
      req = 1'b1; ready = 1'b0;
    end
    #1;
    n_vec++;
    if (o_state !== 2'b01) begin
      n_err++; $display("FAIL wait_last_cycle: got state=%b want 01", o_state);
    end
    @(negedge clk);
    req = 1'b0; ready = 1'b1;
    #1;
    n_vec++;
    if (ctl !== errv || o_stall_cnt !== 16'(WMAX - 1)) begin
      n_err++; $display("FAIL err_entry: got ctl=%b stall=%0d want ctl=%b stall=%0d",
                        ctl, o_stall_cnt, errv, WMAX - 1);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (ctl !== errv) begin
      n_err++; $display("FAIL err_persist: got %b want %b", ctl, errv);
    end
    // Asynchronous reset mid-cycle clears everything without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_state !== 2'b00 || o_error !== 1'b0 || o_stall_cnt !== 16'd0 || o_flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL err_async_reset: got state=%b err=%b stall=%0d flush=%0d want 00/0/0/0",
                        o_state, o_error, o_stall_cnt, o_flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int          low_run, e_stall, e_flush;
    bit          halted, waiting, lu;
    logic [1:0]  fa, fb;
    logic [13:0] want;
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      low_run = 0; halted = 1'b0; e_stall = 0; e_flush = 0;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        waiting = (low_run > 0);
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
        ex_mem_read = ($urandom_range(0, 2) == 0); ex_write_reg = 5'($urandom_range(0, 3));
        mem_reg_write = $urandom_range(0, 1); mem_write_reg = 5'($urandom_range(0, 3));
        wb_reg_write = $urandom_range(0, 1); wb_write_reg = 5'($urandom_range(0, 3));
        branch = ($urandom_range(0, 4) == 0);
        req = ($urandom_range(0, 3) == 0);
        ready = waiting ? ($urandom_range(0, (blk == 3) ? 7 : 2) == 0) : 1'($urandom_range(0, 1));
        #1;
        fa = (mem_reg_write && mem_write_reg != 0 && mem_write_reg == ex_rs) ? 2'b10 :
             (wb_reg_write && wb_write_reg != 0 && wb_write_reg == ex_rs) ? 2'b01 : 2'b00;
        fb = (mem_reg_write && mem_write_reg != 0 && mem_write_reg == ex_rt) ? 2'b10 :
             (wb_reg_write && wb_write_reg != 0 && wb_write_reg == ex_rt) ? 2'b01 : 2'b00;
        lu = ex_mem_read && ex_write_reg != 0 && (ex_write_reg == id_rs || ex_write_reg == id_rt);
        if (halted)              want = mk(0,0,0,0,0,1,1,1,2'b10,fa,fb);
        else if (waiting)        want = ready ? mk(1,1,0,0,0,0,0,0,2'b01,fa,fb)
                                              : mk(0,0,0,0,0,1,1,0,2'b01,fa,fb);
        else if (req && !ready)  want = mk(0,0,0,0,0,1,1,0,2'b00,fa,fb);
        else if (branch)         want = mk(1,1,1,1,1,0,0,0,2'b00,fa,fb);
        else if (lu)             want = mk(0,0,0,1,0,0,0,0,2'b00,fa,fb);
        else                     want = mk(1,1,0,0,0,0,0,0,2'b00,fa,fb);
        n_vec++;
        if (ctl !== want || o_stall_cnt !== 16'(e_stall) || o_flush_cnt !== 16'(e_flush)) begin
          n_err++; $display("FAIL random_b%0d_c%0d: got ctl=%b stall=%0d flush=%0d want ctl=%b stall=%0d flush=%0d",
                            blk, c, ctl, o_stall_cnt, o_flush_cnt, want, e_stall, e_flush);
        end
        if (halted) begin
          // halted until reset
        end else if (waiting) begin
          if (e_stall < 65535) e_stall++;
          if (ready) low_run = 0;
          else begin
            low_run++;
            if (low_run >= int'(WMAX)) begin halted = 1'b1; low_run = 0; end
          end
        end else if (req && !ready) begin
          low_run = 1;
        end else if (branch) begin
          if (e_flush < 65535) e_flush++;
        end else if (lu) begin
          if (e_stall < 65535) e_stall++;
        end
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
